// File: rtl/mini16_mem_arbiter.sv
// mini16_mem_arbiter: shares one single-port data RAM between N_REQ requesters,
// one access per cycle, round-robin (or fixed priority), tagged read return.
// Ports: clk, reset (async, active low); req_valid/req_we/req_addr/req_wdata in,
//   req_ready out (comb one-hot accept); rdata_valid/rdata out (read return);
//   mem_addr/mem_we/mem_wdata out (registered RAM command); mem_rdata in.
// Build option: define MINI16_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mini16_mem_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH_D = 16,
    parameter int DEPTH_D = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_we,
    input  logic [N_REQ*DEPTH_D-1:0]   req_addr,
    input  logic [N_REQ*WIDTH_D-1:0]   req_wdata,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rdata_valid,
    output logic [WIDTH_D-1:0]         rdata,
    output logic [DEPTH_D-1:0]         mem_addr,
    output logic                       mem_we,
    output logic [WIDTH_D-1:0]         mem_wdata,
    input  logic [WIDTH_D-1:0]         mem_rdata
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifndef MINI16_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     r_last;
`endif
    logic [DEPTH_D-1:0] r_mem_addr;
    logic               r_mem_we;
    logic [WIDTH_D-1:0] r_mem_wdata;
    logic               r_s1_rd;
    logic [IDW-1:0]     r_s1_id;
    logic               r_s2_rd;
    logic [IDW-1:0]     r_s2_id;
    logic [WIDTH_D-1:0] r_rdata;

    logic               w_any;
    logic [IDW-1:0]     w_id;
    logic               w_we;
    logic [DEPTH_D-1:0] w_addr;
    logic [WIDTH_D-1:0] w_wdata;
    int                 w_rank;
    int                 w_best;

    // Each requester gets a rank = distance from the slot after the last
    // grant; lowest ranked active requester wins.
    always_comb begin
        w_any   = 1'b0;
        w_id    = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_rank  = 0;
        w_best  = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef MINI16_ARB_FIXED_PRIO_EN
            w_rank = i;
`else
            w_rank = (i + N_REQ - 1 - int'(r_last)) % N_REQ;
`endif
            if (req_valid[i] && (w_rank < w_best)) begin
                w_best  = w_rank;
                w_any   = 1'b1;
                w_id    = IDW'(i);
                w_we    = req_we[i];
                w_addr  = req_addr[i*DEPTH_D +: DEPTH_D];
                w_wdata = req_wdata[i*WIDTH_D +: WIDTH_D];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_any && reset)
            req_ready[w_id] = 1'b1;
    end

    always_comb begin
        rdata_valid = '0;
        if (r_s2_rd)
            rdata_valid[r_s2_id] = 1'b1;
    end

    // RAM data passes straight through on the return cycle, then is held.
    assign rdata     = r_s2_rd ? mem_rdata : r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
`ifndef MINI16_ARB_FIXED_PRIO_EN
            r_last      <= IDW'(N_REQ - 1);
`endif
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_s1_rd     <= 1'b0;
            r_s1_id     <= '0;
            r_s2_rd     <= 1'b0;
            r_s2_id     <= '0;
            r_rdata     <= '0;
        end else begin
            r_s2_rd <= r_s1_rd;
            r_s2_id <= r_s1_id;
            if (r_s2_rd)
                r_rdata <= mem_rdata;
            if (w_any) begin
`ifndef MINI16_ARB_FIXED_PRIO_EN
                r_last      <= w_id;
`endif
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                r_mem_we    <= w_we;
                r_s1_rd     <= ~w_we;
                r_s1_id     <= w_id;
            end else begin
                r_mem_we <= 1'b0;
                r_s1_rd  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mini16_mem_arbiter.sv
// tb_mini16_mem_arbiter: scoreboard bench for mini16_mem_arbiter with a
// behavioural RAM and a reference arbitration model.
module tb_mini16_mem_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_we = '0;
    logic [N*D-1:0] req_addr = '0;
    logic [N*W-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rdata_valid;
    logic [W-1:0]   rdata;
    logic [D-1:0]   mem_addr;
    logic           mem_we;
    logic [W-1:0]   mem_wdata;
    logic [W-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    mini16_mem_arbiter #(.N_REQ(N), .WIDTH_D(W), .DEPTH_D(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rdata_valid(rdata_valid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Unwritten words read as a fixed pattern; 0x10..0x13 hold 0xA0..0xA3.
    function automatic logic [W-1:0] init_val(input int a);
        if (a >= 16 && a < 20) return W'(16'hA0 + a - 16);
        return {8'(a), 8'(~a)};
    endfunction

    bit [W-1:0] ram[256];
    bit         ramw[256];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]  <= mem_wdata;
            ramw[mem_addr] <= 1'b1;
        end
        mem_rdata <= ramw[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
    end

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t       q[$];
    bit [W-1:0] sh[256];
    bit         shw[256];
    int         cyc = 0;
    int         m_last = N - 1;
    bit         pend = 0;
    bit         pend_we = 0;
    logic [D-1:0] pend_a = '0;
    logic [W-1:0] pend_d = '0;
    logic [W-1:0] last_rd = '0;

    always @(negedge clk) begin
        int   g;
        int   a;
        exp_t e;
        cyc++;
        if (!reset) begin
            chk("rst_rdy", 32'(req_ready), 0);
            chk("rst_rv", 32'(rdata_valid), 0);
            chk("rst_we", 32'(mem_we), 0);
            chk("rst_addr", 32'(mem_addr), 0);
            chk("rst_wd", 32'(mem_wdata), 0);
            chk("rst_rd", 32'(rdata), 0);
            q.delete();
            m_last  = N - 1;
            pend    = 0;
            last_rd = '0;
        end else begin
            g = -1;
`ifdef MINI16_ARB_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--)
                if (req_valid[i]) g = i;
`else
            for (int k = 1; k <= N; k++)
                if (g < 0 && req_valid[(m_last + k) % N])
                    g = (m_last + k) % N;
`endif
            chk("rdy", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            if (pend) begin
                chk("m_we", 32'(mem_we), 32'(pend_we));
                chk("m_addr", 32'(mem_addr), 32'(pend_a));
                if (pend_we) chk("m_wd", 32'(mem_wdata), 32'(pend_d));
            end else begin
                chk("m_idle", 32'(mem_we), 0);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rv", 32'(rdata_valid), 32'd1 << e.id);
                chk("rd", 32'(rdata), 32'(e.data));
                last_rd = e.data;
            end else begin
                chk("rv_idle", 32'(rdata_valid), 0);
                chk("rd_hold", 32'(rdata), 32'(last_rd));
            end
            pend = (g >= 0);
            if (g >= 0) begin
                m_last  = g;
                pend_we = req_we[g];
                pend_a  = req_addr[g*D +: D];
                pend_d  = req_wdata[g*W +: W];
                a       = int'(pend_a);
                if (pend_we) begin
                    sh[a]  = pend_d;
                    shw[a] = 1'b1;
                end else begin
                    e.id   = g;
                    e.data = shw[a] ? sh[a] : init_val(a);
                    e.due  = cyc + 2;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic set_req(input int i, input bit we, input int a,
                           input logic [W-1:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*D +: D]   = D'(a);
        req_wdata[i*W +: W]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16 + i, '0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;

        // round robin: first grant 0 after reset
        @(negedge clk);
        chk("first", 32'(req_ready), 32'h1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
`ifndef MINI16_ARB_FIXED_PRIO_EN
            chk("rr", 32'(req_ready), 32'd1 << (k % 4));
            if (k >= 2) begin
                chk("rr_rv", 32'(rdata_valid), 32'd1 << ((k - 2) % 4));
                chk("rr_rd", 32'(rdata), 32'h00A0 + 32'((k - 2) % 4));
            end
`endif
        end
        step();
        req_valid = '0;
        repeat (3) step();

        // write then read-after-write by requester 1
        set_req(1, 1'b1, 8'h05, 16'h1234);
        @(negedge clk);
        chk("wr_rdy", 32'(req_ready), 32'h2);
        step();
        set_req(1, 1'b0, 8'h05, 16'h0);
        @(negedge clk);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 32'h05);
        chk("wr_wd", 32'(mem_wdata), 32'h1234);
        step();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("raw_rv", 32'(rdata_valid), 32'h2);
        chk("raw_rd", 32'(rdata), 32'h1234);
        repeat (2) step();

        // wrap: last grant 2, then 0 and 2 compete
        set_req(2, 1'b0, 8'h20, '0);
        @(negedge clk);
        chk("wrap_a", 32'(req_ready), 32'h4);
        step();
        set_req(0, 1'b0, 8'h21, '0);
        @(negedge clk);
`ifndef MINI16_ARB_FIXED_PRIO_EN
        chk("wrap_b", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("wrap_c", 32'(req_ready), 32'h4);
`endif
        step();
        req_valid = '0;
        repeat (3) step();

        // reset while a read from requester 3 is in flight
        set_req(3, 1'b0, 8'h11, '0);
        @(negedge clk);
        chk("mid_rdy", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rv", 32'(rdata_valid), 0);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16 + i, '0);
        @(negedge clk);
        chk("restart", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (3) step();

`ifdef MINI16_ARB_FIXED_PRIO_EN
        set_req(0, 1'b0, 8'h12, '0);
        set_req(3, 1'b0, 8'h13, '0);
        repeat (20) begin
            @(negedge clk);
            chk("fp_hold", 32'(req_ready), 32'h1);
            step();
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("fp_rel", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        repeat (3) step();
`endif

        // random mixed traffic over a small address window
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i]        = 1'($urandom_range(0, 1));
                req_we[i]           = ($urandom_range(0, 3) == 0);
                req_addr[i*D +: D]  = D'($urandom_range(0, 15));
                req_wdata[i*W +: W] = W'($urandom);
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
        chk("drain", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
